// File: rtl/fft_pkg.sv
// Shared constants, load-FSM state type and lane-index helpers for the
// 8-point FFT frame controller.
package fft_pkg;

  // Sample width per real/imag component and points per frame.
  localparam int DW              = 16;
  localparam int N               = 8;
  localparam int IDXW            = 3;
  // Default watchdog limit, in cycles from core_start to core_done.
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    BUSY = 2'd2
  } ctrl_state_e;

  // Bit offset of lane idx inside a packed N*w frame vector.
  function automatic int lane_lsb(input int idx, input int w);
    return idx * w;
  endfunction

  // Frame index successor, wrapping after the last point.
  function automatic logic [IDXW-1:0] idx_next(input logic [IDXW-1:0] idx);
    return (idx == IDXW'(N - 1)) ? '0 : idx + IDXW'(1);
  endfunction

endpackage

// File: rtl/fft_frame_obuf.sv
// Output frame buffer: captures a full result frame in one cycle and
// streams it out one bin at a time on a valid/ready handshake.
module fft_frame_obuf
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_capture,
  input  logic [N*DW-1:0] i_cap_real,
  input  logic [N*DW-1:0] i_cap_imag,
  input  logic            i_out_ready,
  output logic            o_out_valid,
  output logic [DW-1:0]   o_out_real,
  output logic [DW-1:0]   o_out_imag,
  output logic            o_out_last,
  output logic            o_cap_ok
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  logic [DW-1:0]   r_obuf_real [N];
  logic [DW-1:0]   r_obuf_imag [N];
  logic [DW-1:0]   w_cap_real  [N];
  logic [DW-1:0]   w_cap_imag  [N];
  logic [IDXW-1:0] r_rd_idx;
  logic            r_full;
  logic            w_xfer;
  logic            w_last_xfer;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_cap_real[gi] = i_cap_real[lane_lsb(gi, DW) +: DW];
      assign w_cap_imag[gi] = i_cap_imag[lane_lsb(gi, DW) +: DW];
    end
  endgenerate

  assign w_xfer      = r_full && i_out_ready;
  assign w_last_xfer = w_xfer && (r_rd_idx == LAST_IDX);
  // A new frame may land when the buffer is empty or is emptying this cycle.
  assign o_cap_ok    = !r_full || w_last_xfer;

  // Buffer contents, read pointer and full flag; capture outranks the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= 1'b0;
      r_rd_idx <= '0;
      for (int i = 0; i < N; i++) begin
        r_obuf_real[i] <= '0;
        r_obuf_imag[i] <= '0;
      end
    end else if (i_capture) begin
      r_full   <= 1'b1;
      r_rd_idx <= '0;
      for (int i = 0; i < N; i++) begin
        r_obuf_real[i] <= w_cap_real[i];
        r_obuf_imag[i] <= w_cap_imag[i];
      end
    end else if (w_xfer) begin
      r_rd_idx <= idx_next(r_rd_idx);
      if (w_last_xfer) begin
        r_full <= 1'b0;
      end
    end
  end

  // Presented bin only moves on a transfer, so it is stable under stall.
  assign o_out_valid = r_full;
  assign o_out_real  = r_obuf_real[r_rd_idx];
  assign o_out_imag  = r_obuf_imag[r_rd_idx];
  assign o_out_last  = r_full && (r_rd_idx == LAST_IDX);

endmodule

// File: rtl/fft_8_frame_ctrl.sv
// Frame sequencer around the 8-point FFT core: packs a serial sample
// stream into a frame, runs the core under a watchdog, and hands the
// results to a separate output buffer that drains serially.
module fft_8_frame_ctrl
  import fft_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_real,
  input  logic [DW-1:0]   in_imag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_real,
  output logic [DW-1:0]   out_imag,
  output logic            out_last,
  output logic            core_start,
  input  logic            core_done,
  output logic [N*DW-1:0] core_in_real,
  output logic [N*DW-1:0] core_in_imag,
  input  logic [N*DW-1:0] core_out_real,
  input  logic [N*DW-1:0] core_out_imag,
  output logic [15:0]     frame_cnt,
  output logic            err_timeout
);

  localparam int              WDW        = $clog2(TIMEOUT + 1);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(N - 1);
  // In BUSY the counter lags the cycles since core_start by one, so this
  // value marks the cycle exactly TIMEOUT cycles after the start pulse.
  localparam logic [WDW-1:0]  WDOG_LIMIT = WDW'(TIMEOUT - 1);

  ctrl_state_e     r_state;
  ctrl_state_e     w_state_next;
  logic [IDXW-1:0] r_wr_idx;
  logic [DW-1:0]   r_ibuf_real [N];
  logic [DW-1:0]   r_ibuf_imag [N];
  logic [WDW-1:0]  r_wdog;
  logic [15:0]     r_frame_cnt;
  logic            w_accept;
  logic            w_capture;
  logic            w_cap_ok;
  logic            w_wdog_expired;

  assign w_accept       = in_valid && in_ready;
  assign w_wdog_expired = (r_wdog == WDOG_LIMIT);

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Load FSM next-state: done only counts in BUSY, so a stale done from
  // the previous frame seen during KICK is ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD: begin
        if (w_accept && (r_wr_idx == LAST_IDX)) begin
          w_state_next = KICK;
        end
      end
      KICK: begin
        w_state_next = BUSY;
      end
      BUSY: begin
        if (core_done) begin
          if (w_cap_ok) begin
            w_state_next = LOAD;
          end
        end else if (w_wdog_expired) begin
          w_state_next = LOAD;
        end
      end
      default: begin
        w_state_next = LOAD;
      end
    endcase
  end

  // Load FSM outputs; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready    = 1'b0;
    core_start  = 1'b0;
    err_timeout = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = !rst;
      end
      KICK: begin
        core_start = 1'b1;
      end
      BUSY: begin
        w_capture   = core_done && w_cap_ok;
        err_timeout = !core_done && w_wdog_expired;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Input frame buffer, write index, watchdog and delivered-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_idx    <= '0;
      r_wdog      <= '0;
      r_frame_cnt <= '0;
      for (int i = 0; i < N; i++) begin
        r_ibuf_real[i] <= '0;
        r_ibuf_imag[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_ibuf_real[r_wr_idx] <= in_real;
        r_ibuf_imag[r_wr_idx] <= in_imag;
        r_wr_idx              <= idx_next(r_wr_idx);
      end
      // Watchdog restarts on the kick and freezes while done is held.
      if (r_state == KICK) begin
        r_wdog <= '0;
      end else if ((r_state == BUSY) && !core_done) begin
        r_wdog <= r_wdog + WDW'(1);
      end
      if (w_capture) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pack
      assign core_in_real[lane_lsb(gi, DW) +: DW] = r_ibuf_real[gi];
      assign core_in_imag[lane_lsb(gi, DW) +: DW] = r_ibuf_imag[gi];
    end
  endgenerate

  fft_frame_obuf u_obuf (
    .clk         (clk),
    .rst         (rst),
    .i_capture   (w_capture),
    .i_cap_real  (core_out_real),
    .i_cap_imag  (core_out_imag),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_out_real  (out_real),
    .o_out_imag  (out_imag),
    .o_out_last  (out_last),
    .o_cap_ok    (w_cap_ok)
  );

endmodule

// File: tb/tb_fft_8_frame_ctrl.sv
// Directed bench for fft_8_frame_ctrl with a stub FFT core
// (result = input + 0x10 per lane, done level 12 cycles after start).
module tb_fft_8_frame_ctrl;
  import fft_pkg::*;

  localparam int TMO = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_real = '0;
  logic [DW-1:0]   in_imag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_real;
  logic [DW-1:0]   out_imag;
  logic            out_last;
  logic            core_start;
  logic            core_done = 1'b0;
  logic [N*DW-1:0] core_in_real;
  logic [N*DW-1:0] core_in_imag;
  logic [N*DW-1:0] core_out_real;
  logic [N*DW-1:0] core_out_imag;
  logic [15:0]     frame_cnt;
  logic            err_timeout;

  fft_8_frame_ctrl #(.TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_real       (in_real),
    .in_imag       (in_imag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_real      (out_real),
    .out_imag      (out_imag),
    .out_last      (out_last),
    .core_start    (core_start),
    .core_done     (core_done),
    .core_in_real  (core_in_real),
    .core_in_imag  (core_in_imag),
    .core_out_real (core_out_real),
    .core_out_imag (core_out_imag),
    .frame_cnt     (frame_cnt),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  // Stub core: latches input+0x10 on start, raises done 12 cycles later,
  // holds done until the next start.
  logic            stub_never = 1'b0;
  logic            stub_busy  = 1'b0;
  logic [3:0]      stub_cnt   = '0;
  logic [N*DW-1:0] stub_real  = '0;
  logic [N*DW-1:0] stub_imag  = '0;

  always @(posedge clk) begin
    if (core_start) begin
      core_done <= 1'b0;
      stub_busy <= !stub_never;
      stub_cnt  <= 4'd10;
      for (int i = 0; i < N; i++) begin
        stub_real[i*DW +: DW] <= core_in_real[i*DW +: DW] + 16'h0010;
        stub_imag[i*DW +: DW] <= core_in_imag[i*DW +: DW] + 16'h0010;
      end
    end else if (stub_busy) begin
      if (stub_cnt == 4'd0) begin
        core_done <= 1'b1;
        stub_busy <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 4'd1;
      end
    end
  end

  assign core_out_real = stub_real;
  assign core_out_imag = stub_imag;

  // Event recorder: start/error/accept cycles, delivered bins, stall stability.
  int              cyc = 0;
  int              n_start = 0;
  int              n_err = 0;
  int              start_cyc = -1;
  int              err_cyc = -1;
  int              accept_cyc = -1;
  int              rise_cyc = -1;
  int              stall_viol = 0;
  logic            prev_valid = 1'b0;
  logic            prev_stall = 1'b0;
  logic [DW-1:0]   prev_r = '0;
  logic [DW-1:0]   prev_i = '0;
  logic            prev_l = 1'b0;
  logic [N*DW-1:0] start_snap = '0;
  logic [DW-1:0]   got_real[$];
  logic [DW-1:0]   got_imag[$];
  logic            got_last[$];
  int              got_cyc[$];

  always @(posedge clk) begin
    if (core_start) begin
      n_start++;
      start_cyc  = cyc;
      start_snap = core_in_real;
    end
    if (err_timeout) begin
      n_err++;
      err_cyc = cyc;
    end
    if (in_valid && in_ready) accept_cyc = cyc;
    if (out_valid && !prev_valid) rise_cyc = cyc;
    if (prev_stall && (!out_valid || out_real !== prev_r ||
                       out_imag !== prev_i || out_last !== prev_l)) stall_viol++;
    if (out_valid && out_ready) begin
      got_real.push_back(out_real);
      got_imag.push_back(out_imag);
      got_last.push_back(out_last);
      got_cyc.push_back(cyc);
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_valid = out_valid;
    prev_r     = out_real;
    prev_i     = out_imag;
    prev_l     = out_last;
    cyc++;
  end

  int            n_asserts = 0;
  int            n_fail = 0;
  int            n_checked = 0;
  logic [DW-1:0] exp_real[$];
  logic [DW-1:0] exp_imag[$];
  logic          exp_last[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bins(input logic [DW-1:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      exp_real.push_back(base + 16'(i) + 16'h0010);
      exp_imag.push_back(16'h0010);
      exp_last.push_back(i == N - 1);
    end
  endtask

  task automatic check_bins();
    chk("bin_count", got_real.size(), exp_real.size());
    for (int k = n_checked; k < got_real.size() && k < exp_real.size(); k++) begin
      chk($sformatf("bin%0d_real", k), got_real[k], exp_real[k]);
      chk($sformatf("bin%0d_imag", k), got_imag[k], exp_imag[k]);
      chk($sformatf("bin%0d_last", k), got_last[k], exp_last[k]);
    end
    n_checked = got_real.size();
  endtask

  // Sends 8 samples real=base+i, imag=0; optional 5-cycle pause after sample stall_after.
  task automatic send_frame(input logic [DW-1:0] base, input int stall_after);
    for (int i = 0; i < N; i++) begin
      int   budget;
      logic acc;
      in_valid = 1'b1;
      in_real  = base + 16'(i);
      in_imag  = '0;
      budget   = 0;
      do begin
        acc = in_ready;
        tick();
        budget++;
      end while (!acc && budget < 2000);
      chk("sample_accepted", acc, 1);
      in_valid = 1'b0;
      if (i == stall_after) begin
        int s0;
        s0 = n_start;
        repeat (5) tick();
        chk("stall_no_start", n_start, s0);
        chk("stall_in_ready", in_ready, 1);
      end
    end
  endtask

  task automatic wait_bins(input int n, input int budget);
    int b;
    b = 0;
    while (got_real.size() < n && b < budget) begin
      tick();
      b++;
    end
    chk("wait_bins", got_real.size() >= n, 1);
  endtask

  task automatic wait_valid(input int budget);
    int b;
    b = 0;
    while (!out_valid && b < budget) begin
      tick();
      b++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  initial begin
    int s0;
    int b;
    int base_idx;

    // Reset state.
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_in", core_in_real[31:0], 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single frame with the output always ready.
    out_ready = 1'b1;
    send_frame(16'h0001, -1);
    push_bins(16'h0001, N);
    tick();
    chk("t1_start_latency", start_cyc, accept_cyc + 1);
    chk("t1_pack_lane0", start_snap[15:0], 16'h0001);
    chk("t1_pack_lane7", start_snap[127:112], 16'h0008);
    wait_bins(8, 100);
    chk("t1_valid_latency", rise_cyc, start_cyc + 13);
    chk("t1_n_start", n_start, 1);
    chk("t1_frame_cnt", frame_cnt, 1);
    check_bins();

    // Output backpressure toggling every cycle.
    out_ready = 1'b0;
    send_frame(16'h0021, -1);
    push_bins(16'h0021, N);
    b = 0;
    while (got_real.size() < 16 && b < 300) begin
      out_ready = ~out_ready;
      tick();
      b++;
    end
    chk("t2_done", got_real.size(), 16);
    chk("t2_frame_cnt", frame_cnt, 2);
    check_bins();

    // Back-to-back frames: second capture held until bin 7 of the first drains.
    out_ready = 1'b0;
    tick();
    send_frame(16'h0041, -1);
    push_bins(16'h0041, N);
    wait_valid(100);
    send_frame(16'h0051, -1);
    push_bins(16'h0051, N);
    repeat (30) tick();
    chk("t3_held_valid", out_valid, 1);
    chk("t3_held_bin0", out_real, 16'h0051);
    chk("t3_held_frame_cnt", frame_cnt, 3);
    base_idx = got_real.size();
    out_ready = 1'b1;
    wait_bins(32, 100);
    chk("t3_frame_cnt", frame_cnt, 4);
    check_bins();
    chk("t3_no_gap", got_cyc[base_idx + 8], got_cyc[base_idx + 7] + 1);

    // Watchdog timeout: core never finishes.
    stub_never = 1'b1;
    s0 = n_err;
    send_frame(16'h0071, -1);
    b = 0;
    while (n_err == s0 && b < TMO + 100) begin
      tick();
      b++;
    end
    repeat (3) tick();
    chk("t4_err_pulses", n_err, s0 + 1);
    chk("t4_err_cycle", err_cyc, start_cyc + TMO);
    chk("t4_frame_cnt", frame_cnt, 4);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_in_ready", in_ready, 1);
    check_bins();
    stub_never = 1'b0;
    send_frame(16'h0081, -1);
    push_bins(16'h0081, N);
    wait_bins(40, 100);
    chk("t4_recover_cnt", frame_cnt, 5);
    check_bins();

    // Input stall after sample 3.
    s0 = n_start;
    send_frame(16'h00A1, 3);
    push_bins(16'h00A1, N);
    tick();
    chk("t5_one_start", n_start, s0 + 1);
    chk("t5_start_latency", start_cyc, accept_cyc + 1);
    wait_bins(48, 100);
    chk("t5_frame_cnt", frame_cnt, 6);
    check_bins();

    // Reset mid-drain after bin 4.
    out_ready = 1'b0;
    send_frame(16'h00C1, -1);
    push_bins(16'h00C1, 5);
    wait_valid(100);
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
    chk("t6_in_ready", in_ready, 1);
    check_bins();
    out_ready = 1'b1;
    send_frame(16'h00D1, -1);
    push_bins(16'h00D1, N);
    wait_bins(61, 100);
    chk("t6_frame_cnt_after", frame_cnt, 1);
    check_bins();

    chk("stall_stability", stall_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fft_8_frame_ctrl.md
Name: fft_8_frame_ctrl

Overview:
Frame sequencer wrapped around the 8-point FFT core (fft_8_sol0_gen2 family: parallel 8x16-bit real/imag inputs and outputs, start pulse, done level).
- Accepts a serial sample stream on a valid/ready handshake and packs 8 samples into an input frame buffer.
- Pulses the core start, waits for done with a watchdog, and captures the 8 results into an output buffer.
- Streams the results out serially with a last marker.
- The output buffer is separate from the input buffer, so the next frame loads while the previous one drains.

Parameters:
- DW, 16, sample width per real/imag component
- N, 8, points per frame (fixed to 8; index width 3)
- TIMEOUT, 1024, max cycles from core_start to core_done before abort

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  controller can accept a sample
- in_real  in  DW  input sample, real part
- in_imag  in  DW  input sample, imag part
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the sample
- out_real  out  DW  output bin, real part
- out_imag  out  DW  output bin, imag part
- out_last  out  1  high with bin 7
- core_start  out  1  one-cycle start pulse to the FFT core
- core_done  in  1  core done level; valid from assertion until the next start
- core_in_real  out  N*DW  packed frame to the core; sample i at bits [i*DW +: DW]
- core_in_imag  out  N*DW  same packing, imag part
- core_out_real  in  N*DW  packed core results, real part
- core_out_imag  in  N*DW  packed core results, imag part
- frame_cnt  out  16  completed frames delivered to the output buffer; wraps
- err_timeout  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset values: all outputs 0, buffers 0, FSM in LOAD, wr_idx=0, rd_idx=0, obuf_full=0. in_ready becomes 1 on the first cycle after reset deasserts.
- Load FSM states: LOAD, KICK, BUSY.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready, write sample to ibuf[wr_idx] and increment wr_idx.
  - Accepting the sample at wr_idx=7 moves to KICK and wraps wr_idx to 0.
- KICK:
  - core_start = 1 for exactly this cycle; in_ready = 0.
  - Resets the watchdog counter; next state BUSY.
- BUSY:
  - in_ready = 0; ibuf is held stable, and core_in_* reflect ibuf registers at all times.
  - Watchdog increments every cycle.
  - If core_done && !obuf_full: copy core_out_* into obuf, set obuf_full, increment frame_cnt, go to LOAD.
  - If core_done && obuf_full: stay in BUSY. The watchdog is frozen while done is held, and the capture happens on the first cycle obuf_full is clear.
  - If the watchdog reaches TIMEOUT without done: pulse err_timeout, discard the frame (no obuf write, frame_cnt unchanged), go to LOAD.
- Capture is ignored for core_done seen in the KICK cycle; only done in BUSY counts, so a stale done from the previous frame is not accepted.
- Unload side, independent of the load FSM:
  - out_valid = obuf_full; out_real/imag = obuf[rd_idx]; out_last = obuf_full && rd_idx==7.
  - On out_valid && out_ready, rd_idx increments.
  - The transfer at rd_idx=7 clears obuf_full and wraps rd_idx to 0.
  - out_real/imag/last must not change while out_valid && !out_ready.
- Simultaneous events:
  - Last-bin transfer and capture in the same cycle: capture wins, obuf_full stays 1, rd_idx resets to 0. Capture is enabled by obuf_full being clear or by a last transfer happening this cycle.
  - Reset mid-frame discards partial input and undelivered output; frame_cnt is cleared.
- Latency:
  - Last input accepted at cycle t: core_start at t+1.
  - core_done sampled at cycle d: out_valid at d+1, assuming the output buffer is free.

Decomposition:
- Package fft_pkg: DW, N, IDXW=3, the ctrl_state_e enum {LOAD, KICK, BUSY}, and the pack/unpack index helpers.
- One natural sub-module: fft_frame_obuf, holding the output buffer, rd_idx, obuf_full and the valid/ready/last logic.

Test Plan:
- Single frame: send inputs real=i+1, imag=0 for i=0..7 against a stub core (out = in+0x10, done 12 cycles after start) -> one core_start pulse; out_real 0x0011..0x0018; out_last only on the 8th bin; frame_cnt=1.
- Backpressure: out_ready toggling 1/0 every cycle -> all 8 bins delivered in order, no duplicates, data stable while stalled.
- Back-to-back frames with out_ready=0 during frame 2's done: frame 2's capture is held until bin 7 of frame 1 transfers, then obuf holds frame 2 -> 16 bins out in order, frame_cnt=2.
- Timeout: stub core never asserts done -> err_timeout pulses at start+TIMEOUT; no output; frame_cnt=0; next 8 inputs process normally.
- Input stall: in_valid low for 5 cycles after sample 3 -> wr_idx holds; core_start fires only after the 8th accepted sample.
- Reset mid-drain: rst high for 1 cycle after bin 4 -> out_valid=0, frame_cnt=0, in_ready=1 the next cycle; the following frame outputs start at bin 0.
